// File: rtl/fermat_modmul_pipe.sv
// fermat_modmul_pipe: three-stage streaming modular multiplier, modulo the
// Fermat prime PRIME = 2**M+1.
//   S1 registers the operands, S2 the double-width product and S3 the
//   reduced result. Reduction folds the product as lo - hi and adds PRIME
//   once if the difference is negative.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  operand handshake (in_ready is combinational)
//   a, b               operands, canonical residues 0..PRIME-1
//   out_valid/out_ready result handshake
//   result             (a*b) mod PRIME
//   busy               any stage holds valid data
//   range_err          sticky out-of-range operand flag (only with
//                      FERMAT_MODMUL_RANGE_CHECK_EN defined)
// Optional feature macro: FERMAT_MODMUL_RANGE_CHECK_EN
module fermat_modmul_pipe #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned M     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
`ifdef FERMAT_MODMUL_RANGE_CHECK_EN
  output logic             range_err,
`endif
  output logic             busy
);

  localparam int unsigned PRIME = (32'd1 << M) + 32'd1;
  localparam int unsigned PW    = 2 * M + 1;  // product width, max 2**(2M)
  localparam int unsigned TW    = M + 2;      // signed fold width

  logic             en_c;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s2_valid;
  logic [PW-1:0]    s2_p;
  logic [PW-1:0]    prod_c;
  logic [M-1:0]     lo_c;
  logic [M:0]       hi_c;
  logic [TW-1:0]    diff_c;
  logic [TW-1:0]    red_c;
  logic [WIDTH-1:0] res_next_c;

  // Whole pipe advances together whenever the output slot is free or draining.
  assign en_c     = !out_valid || out_ready;
  assign in_ready = en_c;
  assign busy     = s1_valid | s2_valid | out_valid;

  // S1: operand register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (en_c) begin
      s1_valid <= in_valid;
      s1_a     <= a;
      s1_b     <= b;
    end
  end

  assign prod_c = PW'(s1_a) * PW'(s1_b);

  // S2: product register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_p     <= '0;
    end else if (en_c) begin
      s2_valid <= s1_valid;
      s2_p     <= prod_c;
    end
  end

  // 2**M == -1 mod PRIME, so P = hi*2**M + lo folds to lo - hi.
  always_comb begin
    lo_c   = s2_p[M-1:0];
    hi_c   = s2_p[PW-1:M];
    diff_c = TW'(lo_c) - TW'(hi_c);
    red_c  = diff_c[TW-1] ? (diff_c + TW'(PRIME)) : diff_c;
  end

`ifdef FERMAT_MODMUL_RANGE_CHECK_EN
  logic bad_c;
  logic s1_bad;
  logic s2_bad;

  assign bad_c = (a >= WIDTH'(PRIME)) || (b >= WIDTH'(PRIME));

  // Out-of-range tag travels with its op so only that result is zeroed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_bad    <= 1'b0;
      s2_bad    <= 1'b0;
      range_err <= 1'b0;
    end else begin
      if (en_c) begin
        s1_bad <= in_valid && bad_c;
        s2_bad <= s1_bad;
      end
      if (in_valid && en_c && bad_c) begin
        range_err <= 1'b1;
      end
    end
  end

  assign res_next_c = s2_bad ? '0 : WIDTH'(red_c);
`else
  assign res_next_c = WIDTH'(red_c);
`endif

  // S3: output register; result only loads with a valid op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else if (en_c) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        result <= res_next_c;
      end
    end
  end

endmodule

// File: tb/tb_fermat_modmul_pipe.sv
// Directed self-checking bench for fermat_modmul_pipe (PRIME = 65537).
module tb_fermat_modmul_pipe;

  localparam int unsigned WIDTH = 18;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;
`ifdef FERMAT_MODMUL_RANGE_CHECK_EN
  logic             range_err;
`endif

  int n_cmp;
  int n_bad;

  fermat_modmul_pipe #(.WIDTH(WIDTH), .M(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
`ifdef FERMAT_MODMUL_RANGE_CHECK_EN
    .range_err (range_err),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  logic [WIDTH-1:0] va [8];
  logic [WIDTH-1:0] vb [8];
  logic [WIDTH-1:0] ve [8];
  logic [WIDTH-1:0] sa [4];
  logic [WIDTH-1:0] sb [4];
  logic [WIDTH-1:0] se [4];
  int               got;
  logic             acc;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    // hand-computed residues mod 65537 (65536 == -1)
    va = '{18'd65536, 18'd256, 18'd65535, 18'd256, 18'd0,     18'd1,     18'd3,     18'd65536};
    vb = '{18'd65536, 18'd512, 18'd2,     18'd256, 18'd12345, 18'd65536, 18'd21846, 18'd2};
    ve = '{18'd1,     18'd65535, 18'd65533, 18'd65536, 18'd0, 18'd65536, 18'd1,     18'd65535};
    sa = '{18'd2, 18'd7, 18'd100,   18'd300};
    sb = '{18'd3, 18'd9, 18'd100,   18'd300};
    se = '{18'd6, 18'd63, 18'd10000, 18'd24463};

    // reset state
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #7;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(result), 32'd0);
`ifdef FERMAT_MODMUL_RANGE_CHECK_EN
    check("rst_range_err", 32'(range_err), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // single op, latency and busy window
    in_valid = 1'b1; a = 18'd2; b = 18'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat1_out_valid", 32'(out_valid), 32'd0);
    check("lat1_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("lat2_out_valid", 32'(out_valid), 32'd0);
    check("lat2_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("lat3_out_valid", 32'(out_valid), 32'd1);
    check("lat3_result", 32'(result), 32'd6);
    check("lat3_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("lat4_out_valid", 32'(out_valid), 32'd0);
    check("lat4_busy", 32'(busy), 32'd0);

    // back-to-back stream of 8 corner-value ops
    for (int i = 0; i < 11; i++) begin
      in_valid = (i < 8);
      a = (i < 8) ? va[i] : '0;
      b = (i < 8) ? vb[i] : '0;
      @(posedge clk); #1;
      check($sformatf("stream_in_ready_%0d", i), 32'(in_ready), 32'd1);
      check($sformatf("stream_out_valid_%0d", i), 32'(out_valid), 32'((i >= 2) && (i < 10)));
      if (i >= 2 && i < 10) begin
        check($sformatf("stream_result_%0d", i - 2), 32'(result), 32'(ve[i-2]));
      end
    end
    in_valid = 1'b0;
`ifdef FERMAT_MODMUL_RANGE_CHECK_EN
    check("stream_range_err", 32'(range_err), 32'd0);
`endif

    // stall: fill with out_ready low, hold 5 cycles, then drain
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = sa[k]; b = sb[k];
      @(posedge clk); #1;
    end
    a = sa[3]; b = sb[3];
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall_out_valid_%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("stall_result_%0d", k), 32'(result), 32'(se[0]));
      check($sformatf("stall_in_ready_%0d", k), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    got = 0;
    for (int c = 0; c < 8; c++) begin
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (got < 4) check($sformatf("drain_result_%0d", got), 32'(result), 32'(se[got]));
        got++;
      end
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    check("drain_count", 32'(got), 32'd4);
    check("drain_busy", 32'(busy), 32'd0);

    // asynchronous reset with 3 ops in flight
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = sa[k+1]; b = sb[k+1];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst_out_valid_%0d", k), 32'(out_valid), 32'd0);
      check($sformatf("post_rst_busy_%0d", k), 32'(busy), 32'd0);
    end
    in_valid = 1'b1; a = 18'd7; b = 18'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("new_op_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("new_op_out_valid", 32'(out_valid), 32'd1);
    check("new_op_result", 32'(result), 32'd63);

`ifdef FERMAT_MODMUL_RANGE_CHECK_EN
    // out-of-range operand, then a good op behind it
    @(posedge clk); #1;
    in_valid = 1'b1; a = 18'd65537; b = 18'd5;
    @(posedge clk); #1;
    check("rc_err_set", 32'(range_err), 32'd1);
    a = 18'd4; b = 18'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rc_bad_valid", 32'(out_valid), 32'd1);
    check("rc_bad_result", 32'(result), 32'd0);
    @(posedge clk); #1;
    check("rc_good_valid", 32'(out_valid), 32'd1);
    check("rc_good_result", 32'(result), 32'd16);
    check("rc_err_sticky", 32'(range_err), 32'd1);
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
